// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for the bit-serial adder.
// The master side offers operands and accepts results; the slave side is the adder.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: two half adders plus a carry flop add one bit per clock,
// LSB first, between an operand handshake and a result handshake.
module ha (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  serial_adder_if.slave bus
);
  localparam int            CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_r;
  logic [WIDTH-1:0] sum_next;
  logic [CW-1:0]    count;
  logic             carry;
  logic             cout_r;
  logic             out_valid_r;
  logic             busy_r;

  logic p;
  logic g0;
  logic s;
  logic g1;
  logic c;

  ha u_ha0 (.x(a_sh[0]), .y(b_sh[0]), .s(p), .c(g0));
  ha u_ha1 (.x(p),       .y(carry),   .s(s), .c(g1));
  assign c = g0 | g1;

  // New sum bit enters at the MSB so the LSB lands in bit 0 after WIDTH shifts.
  always_comb begin
    sum_next            = sum_r >> 1;
    sum_next[WIDTH-1]   = s;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      a_sh        <= '0;
      b_sh        <= '0;
      carry       <= 1'b0;
      count       <= '0;
      sum_r       <= '0;
      cout_r      <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_sh   <= bus.a;
            b_sh   <= bus.b;
            carry  <= bus.cin;
            count  <= '0;
            busy_r <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          sum_r <= sum_next;
          carry <= c;
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          count <= count + CW'(1);
          if (count == LAST) begin
            cout_r      <= c;
            out_valid_r <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // in_ready is forced low during reset so nothing is offered before the FSM is known.
  assign bus.in_ready  = (state == IDLE) && !rst;
  assign bus.out_valid = out_valid_r;
  assign bus.sum       = sum_r;
  assign bus.cout      = cout_r;
  assign bus.busy      = busy_r;

  a_result_held: assert property (@(posedge clk) disable iff (rst)
    out_valid_r && !bus.out_ready |=> out_valid_r && $stable(sum_r) && $stable(cout_r));

  a_no_accept_while_busy: assert property (@(posedge clk) disable iff (rst)
    !(busy_r && bus.in_ready));
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8 and WIDTH=1 with a result scoreboard.
module tb_serial_adder;
  logic clk;
  logic rst;

  serial_adder_if #(.WIDTH(8)) bus8 ();
  serial_adder_if #(.WIDTH(1)) bus1 ();

  serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  serial_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
  } vec_t;

  int         vectors     = 0;
  int         miscompares = 0;
  logic [8:0] exp_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endfunction

  function automatic logic ov(input bit n);
    return n ? bus1.out_valid : bus8.out_valid;
  endfunction

  function automatic logic ir(input bit n);
    return n ? bus1.in_ready : bus8.in_ready;
  endfunction

  function automatic logic bz(input bit n);
    return n ? bus1.busy : bus8.busy;
  endfunction

  function automatic logic [8:0] res(input bit n);
    return n ? {7'b0, bus1.cout, bus1.sum} : {bus8.cout, bus8.sum};
  endfunction

  task automatic drive(input bit n, input logic v, input logic [7:0] a, input logic [7:0] b,
                       input logic cin);
    if (n) begin
      bus1.in_valid = v;
      bus1.a        = a[0:0];
      bus1.b        = b[0:0];
      bus1.cin      = cin;
    end else begin
      bus8.in_valid = v;
      bus8.a        = a;
      bus8.b        = b;
      bus8.cin      = cin;
    end
  endtask

  task automatic set_out_ready(input bit n, input logic r);
    if (n) bus1.out_ready = r;
    else   bus8.out_ready = r;
  endtask

  // Offer one operand pair, wait for acceptance and push the expected result.
  task automatic apply_stimulus(input bit n, input logic [7:0] a, input logic [7:0] b,
                                input logic cin, input logic [8:0] exp);
    int guard = 0;
    while (!ir(n) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!ir(n)) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL accept_timeout: got in_ready=0, want 1");
    end
    drive(n, 1'b1, a, b, cin);
    exp_q.push_back(exp);
    @(negedge clk);
    drive(n, 1'b0, a, b, cin);
  endtask

  // Wait for out_valid, compare latency and result, optionally hold backpressure or
  // keep offering junk operands, then retire the result.
  task automatic check_output(input bit n, input string name, input int hold, input bit junk);
    int         lat = 0;
    logic [8:0] exp;
    while (!ov(n) && lat < 40) begin
      if (junk) drive(n, 1'b1, 8'hC3, 8'h3C, 1'b1);
      if (lat == 0) check({name, "_busy"}, 32'(bz(n)), 32'd1);
      @(negedge clk);
      lat++;
    end
    check({name, "_latency"}, 32'(lat), n ? 32'd1 : 32'd8);
    if (exp_q.size() > 0) exp = exp_q.pop_front();
    else begin
      exp = 9'h1FF;
      $display("[TB] scoreboard empty at %s", name);
    end
    check({name, "_result"}, 32'(res(n)), 32'(exp));
    for (int i = 0; i < hold; i++) begin
      if (junk) drive(n, 1'b1, 8'hC3, 8'h3C, 1'b1);
      @(negedge clk);
      check({name, "_hold_valid"}, 32'(ov(n)), 32'd1);
      check({name, "_hold_result"}, 32'(res(n)), 32'(exp));
    end
    drive(n, 1'b0, 8'h00, 8'h00, 1'b0);
    set_out_ready(n, 1'b1);
    @(negedge clk);
    set_out_ready(n, 1'b0);
    check({name, "_retired"}, 32'(ov(n)), 32'd0);
    check({name, "_ready_again"}, 32'(ir(n)), 32'd1);
  endtask

  initial begin
    vec_t       vecs[8];
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rc;
    logic [8:0] model;

    vecs[0] = '{8'h5A, 8'hA5, 1'b0, 8'hFF, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[5] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};
    vecs[6] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
    vecs[7] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1};

    rst = 1'b1;
    drive(0, 1'b0, 8'h00, 8'h00, 1'b0);
    drive(1, 1'b0, 8'h00, 8'h00, 1'b0);
    set_out_ready(0, 1'b0);
    set_out_ready(1, 1'b0);
    repeat (3) @(negedge clk);

    check("rst_in_ready", 32'(ir(0)), 32'd0);
    check("rst_out_valid", 32'(ov(0)), 32'd0);
    check("rst_result", 32'(res(0)), 32'd0);
    check("rst_busy", 32'(bz(0)), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(ir(0)), 32'd1);

    set_out_ready(0, 1'b1);
    @(negedge clk);
    check("idle_out_ready_valid", 32'(ov(0)), 32'd0);
    check("idle_out_ready_in_ready", 32'(ir(0)), 32'd1);
    set_out_ready(0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      apply_stimulus(0, vecs[i].a, vecs[i].b, vecs[i].cin, {vecs[i].cout, vecs[i].sum});
      check_output(0, $sformatf("vec%0d", i), 0, 1'b0);
    end

    apply_stimulus(0, 8'hFF, 8'h01, 1'b0, 9'h100);
    check_output(0, "backpressure", 5, 1'b0);

    apply_stimulus(0, 8'h33, 8'h44, 1'b0, 9'h077);
    check_output(0, "ignore_in_valid", 2, 1'b1);

    // Reset lands on the 4th SHIFT edge after acceptance.
    apply_stimulus(0, 8'h0F, 8'h0F, 1'b0, 9'h000);
    void'(exp_q.pop_back());
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_out_valid", 32'(ov(0)), 32'd0);
    check("midrst_result", 32'(res(0)), 32'd0);
    check("midrst_busy", 32'(bz(0)), 32'd0);
    check("midrst_in_ready", 32'(ir(0)), 32'd1);
    repeat (10) @(negedge clk);
    check("midrst_no_late_valid", 32'(ov(0)), 32'd0);
    apply_stimulus(0, 8'h01, 8'h01, 1'b0, 9'h002);
    check_output(0, "after_rst", 0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      ra    = 8'(i & 1);
      rb    = 8'((i >> 1) & 1);
      rc    = 1'((i >> 2) & 1);
      model = 9'(ra) + 9'(rb) + 9'(rc);
      apply_stimulus(1, ra, rb, rc, model);
      check_output(1, $sformatf("w1_combo%0d", i), 0, 1'b0);
    end

    for (int i = 0; i < 1000; i++) begin
      ra    = 8'($urandom_range(0, 255));
      rb    = 8'($urandom_range(0, 255));
      rc    = 1'($urandom_range(0, 1));
      model = {1'b0, ra} + {1'b0, rb} + 9'(rc);
      apply_stimulus(0, ra, rb, rc, model);
      check_output(0, $sformatf("rand%0d", i), 0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
